// File: rtl/freq_meter.sv
// freq_meter: counts synchronized rising edges of sig_in over a fixed
// sysclk gate window and publishes one registered count per window.
module freq_meter #(
    parameter int GATE_CYCLES = 100000000,
    parameter int COUNT_W     = 27
) (
    input  logic               sysclk,
    input  logic               rst_n,
    input  logic               meas_en,
    input  logic               sig_in,
    output logic [COUNT_W-1:0] freq,
    output logic               freq_valid,
    output logic               overflow,
    output logic               busy
);

    localparam int GW = $clog2(GATE_CYCLES);
    localparam logic [GW-1:0] LAST = GW'(GATE_CYCLES - 1);
    localparam logic [COUNT_W-1:0] MAX = '1;

    typedef enum logic [1:0] {
        IDLE,
        GATE,
        DONE
    } state_t;

    state_t             state;
    logic               s1, s2, s3;
    logic               rise;
    logic               at_max;
    logic               ovf;
    logic [GW-1:0]      gate_cnt;
    logic [COUNT_W-1:0] edge_cnt;

    assign rise   = s2 & ~s3;
    assign at_max = (edge_cnt == MAX);

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            s1         <= 1'b0;
            s2         <= 1'b0;
            s3         <= 1'b0;
            state      <= IDLE;
            gate_cnt   <= '0;
            edge_cnt   <= '0;
            ovf        <= 1'b0;
            freq       <= '0;
            freq_valid <= 1'b0;
            overflow   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            s1         <= sig_in;
            s2         <= s1;
            s3         <= s2;
            freq_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    gate_cnt <= '0;
                    edge_cnt <= '0;
                    ovf      <= 1'b0;
                    if (meas_en) begin
                        state <= GATE;
                        busy  <= 1'b1;
                    end
                end
                GATE: begin
                    // Abort wins over completion; the partial window is dropped.
                    if (!meas_en) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        if (rise) begin
                            if (at_max) ovf <= 1'b1;
                            else edge_cnt <= edge_cnt + COUNT_W'(1);
                        end
                        if (gate_cnt == LAST) begin
                            state <= DONE;
                            busy  <= 1'b0;
                        end else begin
                            gate_cnt <= gate_cnt + GW'(1);
                        end
                    end
                end
                DONE: begin
                    freq       <= edge_cnt;
                    overflow   <= ovf;
                    freq_valid <= 1'b1;
                    gate_cnt   <= '0;
                    edge_cnt   <= '0;
                    ovf        <= 1'b0;
                    if (meas_en) begin
                        state <= GATE;
                        busy  <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/freq_meter.md
# freq_meter

Measures the frequency of an asynchronous input signal by counting its rising edges over a fixed gate window timed from `sysclk`. It pairs with the team's clock dividers: they generate known slow clocks from `sysclk`, and this block recovers an unknown rate back into a number. The block sits between an external or divided signal source and display/compare logic. It publishes one registered count per window with a single-cycle valid strobe.

## Interface

- `GATE_CYCLES`, default 100000000: gate window length in `sysclk` cycles. This gives 1 s at 100 MHz, so `freq` reads directly in Hz. Must be ≥ 2.
- `COUNT_W`, default 27: width of the edge counter and of `freq`.

Ports:

- `sysclk`, input, 1: the single system clock; all logic is on its rising edge.
- `rst_n`, input, 1: asynchronous reset, active-low.
- `meas_en`, input, 1: synchronous enable. High means measure continuously; low means abort and idle.
- `sig_in`, input, 1: signal under measurement, asynchronous to `sysclk`.
- `freq`, output, COUNT_W: count from the last completed window, held until the next completion.
- `freq_valid`, output, 1: one-cycle strobe when `freq` updates.
- `overflow`, output, 1: the last completed window saturated the counter. Updated together with `freq`.
- `busy`, output, 1: high while a gate window is open.

## Operation

- **Input path:** `sig_in` passes through a 2-flop synchronizer (s1, s2), then a third flop s3. `rise = s2 & ~s3`.
- **FSM states:** IDLE, GATE, DONE. Reset state is IDLE.
- **IDLE:**
  - gate_cnt = 0, edge_cnt = 0, ovf = 0.
  - `meas_en` = 1 → GATE on the next cycle.
- **GATE:**
  - gate_cnt increments every cycle.
  - edge_cnt increments when `rise` = 1, saturating at 2^COUNT_W − 1.
  - A `rise` while edge_cnt is already at max sets the sticky ovf.
  - When gate_cnt == GATE_CYCLES−1 and `meas_en` = 1:
    - Next state is DONE.
    - A `rise` in this final cycle is counted.
    - `freq` ← final edge_cnt, `overflow` ← final ovf.
  - `meas_en` = 0 in any GATE cycle → IDLE next cycle.
    - The window is discarded: no `freq_valid`; `freq` and `overflow` hold.
    - `meas_en` takes priority over window completion.
- **DONE** (exactly one cycle):
  - `freq_valid` = 1.
  - Counters and ovf are cleared.
  - `rise` is ignored.
  - `meas_en` = 1 → GATE; otherwise → IDLE.
- **Window spacing:** back-to-back windows repeat every GATE_CYCLES+1 cycles, with one dead cycle (DONE) between them.
- **Input rate limit:** rates above `sysclk`/2 are unmeasurable. Each high and low phase of `sig_in` must last ≥ 1 `sysclk` period.
- **Registered outputs:** `busy` is 1 exactly when state = GATE. All outputs are registered.

## Timing

- **Reset:** `rst_n` low asynchronously forces `freq` = 0, `freq_valid` = 0, `overflow` = 0, `busy` = 0, state IDLE, and all counters and synchronizer flops to 0. It takes effect mid-window with no completion.
- **Start latency:** `meas_en` sampled high in IDLE at edge t → `busy` = 1 from t+1.
- **Completion:** the window covers cycles t+1 … t+GATE_CYCLES. `freq` and `freq_valid` update at edge t+GATE_CYCLES+1. `freq_valid` falls at the next edge.
- **Synchronizer latency:** an input rising edge shows up as `rise` 2–3 `sysclk` edges later. The window is offset by that amount, but its length is exact.
- **Exact-count property:** if `sig_in` has period P with GATE_CYCLES a multiple of P, every window counts exactly GATE_CYCLES/P edges, independent of phase.
- **Abort latency:** `meas_en` low at edge k → `busy` = 0 from k+1.
- **Re-enable:** raising `meas_en` after an abort starts a full new window. No partial count carries over.

## Test plan

All scenarios use `GATE_CYCLES` = 100 and `COUNT_W` = 27 unless stated otherwise.

- **Reset:** `rst_n` = 0 with `sig_in` toggling → `freq` = 0, `freq_valid` = 0, `overflow` = 0, `busy` = 0. Release with `meas_en` = 0 → stays IDLE, `busy` = 0.
- **Period-10 input:** `meas_en` = 1, `sig_in` period 10 (5 high / 5 low), any phase → each `freq_valid` pulse is one cycle wide with `freq` = 10 and `overflow` = 0. Pulses are spaced exactly 101 cycles apart, the first at 101 cycles after `busy` rises.
- **Fastest and stuck inputs:**
  - `sig_in` period 2 → `freq` = 50.
  - `sig_in` period 4 → `freq` = 25.
  - `sig_in` held at 1 → `freq` = 0.
- **Overflow:** `COUNT_W` = 5, `sig_in` period 2.
  - Expect `freq` = 31, `overflow` = 1.
  - Then switch to period 4 for a full window → `freq` = 25, `overflow` = 0.
- **Abort:** drop `meas_en` at gate cycle 50.
  - `busy` falls next cycle, no `freq_valid`, and `freq` keeps its previous value of 10.
  - Re-raise `meas_en` → a full 100-cycle window, then `freq` = 10.
- **Reset mid-window:** pull `rst_n` low at gate cycle 70 → all outputs go to 0 immediately, without waiting for a clock edge. After release with `meas_en` = 1 → the first valid `freq` arrives 101 cycles after `busy` rises.
